// File: rtl/matriz_pkg.sv
// Shared types and constants for the parking LED matrix scanner.
// Holds the FSM encoding and the spot-to-matrix position mapping.
package matriz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int N_COLS      = 2;
  localparam int N_ROWS_USED = 4;
  localparam int N_ROWS      = 7;

  localparam logic [N_ROWS-1:0] ROW_ALL_OFF = 7'h7F;

  // Column c, row r shows spot[2*r + c].
  function automatic logic [2:0] spot_map(
    input logic       c,
    input logic [1:0] r
  );
    return {r, c};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous spot sensor inputs.
// Both stages clear to zero on reset.
module sync_2ff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/matriz_scan_ctrl.sv
// Column scan controller for the 2x7 parking LED matrix.
// Snapshots synchronized spot inputs once per frame and blanks between columns.
module matriz_scan_ctrl
  import matriz_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int BLANK_CYC = 1,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  spot,
  output logic [1:0]  col,
  output logic [6:0]  row_n,
  output logic        frame_start,
  output logic [3:0]  occupied_cnt
);

  localparam int BL_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BL_LAST);

  logic [7:0]       spot_s;
  state_t           state_q, state_d;
  logic             idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       snap_q;
  logic [3:0]       occ_q;
  logic             load;

  sync_2ff #(.W(8)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spot),
    .q     (spot_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      cnt_q   <= '0;
      snap_q  <= 8'hFF;
      occ_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (load) begin
        snap_q <= spot_s;
        occ_q  <= 4'($countones(spot_s));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHOW;
          idx_d   = 1'b0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYC > 0) begin
            state_d = BLANK;
          end else begin
            idx_d = ~idx_q;
            load  = idx_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = ~idx_q;
          load    = idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only; nothing from en/spot reaches them.
  always_comb begin
    col         = 2'b00;
    row_n       = ROW_ALL_OFF;
    frame_start = 1'b0;
    if (state_q == SHOW) begin
      col         = idx_q ? 2'b10 : 2'b01;
      frame_start = !idx_q && (cnt_q == '0);
      for (int r = 0; r < N_ROWS_USED; r++) begin
        row_n[r] = snap_q[spot_map(idx_q, 2'(r))];
      end
    end
  end

  assign occupied_cnt = occ_q;

endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// Bench for matriz_scan_ctrl: two parameterizations checked each cycle
// against a frame-position reference model.
module tb_matriz_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] spot = 8'h00;

  logic [1:0] col_a, col_b;
  logic [6:0] row_a, row_b;
  logic       fs_a, fs_b;
  logic [3:0] occ_a, occ_b;

  always #5 clk = ~clk;

  matriz_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(1), .CNT_W(8)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .spot         (spot),
    .col          (col_a),
    .row_n        (row_a),
    .frame_start  (fs_a),
    .occupied_cnt (occ_a)
  );

  matriz_scan_ctrl #(.CLK_DIV(1), .BLANK_CYC(0), .CNT_W(8)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .spot         (spot),
    .col          (col_b),
    .row_n        (row_b),
    .frame_start  (fs_b),
    .occupied_cnt (occ_b)
  );

  int errors = 0;
  int checks = 0;

  int         cd [2];
  int         bc [2];
  bit         run [2];
  int         p [2];
  logic [7:0] snap [2];
  logic [3:0] occ [2];
  logic [7:0] h0, h1;

  function automatic logic [3:0] pop(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(v[k]);
    return 4'(n);
  endfunction

  task automatic chk(input string tag, input int i,
                     input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h t=%0t",
             tag, i, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run[i]  = 1'b0;
      p[i]    = 0;
      snap[i] = 8'hFF;
      occ[i]  = 4'd0;
    end
    h0 = 8'h00;
    h1 = 8'h00;
  endtask

  // spot_s seen at an edge is the spot value present two edges earlier.
  task automatic model_edge();
    logic [7:0] ss;
    ss = h1;
    for (int i = 0; i < 2; i++) begin
      if (!run[i]) begin
        if (en) begin
          run[i]  = 1'b1;
          p[i]    = 0;
          snap[i] = ss;
          occ[i]  = pop(ss);
        end
      end else if (!en) begin
        run[i] = 1'b0;
      end else begin
        p[i] = (p[i] + 1) % (2 * (cd[i] + bc[i]));
        if (p[i] == 0) begin
          snap[i] = ss;
          occ[i]  = pop(ss);
        end
      end
    end
    h1 = h0;
    h0 = spot;
  endtask

  task automatic check_all();
    logic [1:0] ec;
    logic [6:0] er;
    logic       ef;
    int         f, c, o;
    for (int i = 0; i < 2; i++) begin
      ec = 2'b00;
      er = 7'h7F;
      ef = 1'b0;
      if (run[i]) begin
        f = p[i];
        c = f / (cd[i] + bc[i]);
        o = f % (cd[i] + bc[i]);
        if (o < cd[i]) begin
          ec = (c == 1) ? 2'b10 : 2'b01;
          for (int r = 0; r < 4; r++) er[r] = snap[i][2*r+c];
          ef = (f == 0);
        end
      end
      chk("col", i, {6'b0, (i == 1) ? col_b : col_a}, {6'b0, ec});
      chk("row_n", i, {1'b0, (i == 1) ? row_b : row_a}, {1'b0, er});
      chk("frame_start", i, {7'b0, (i == 1) ? fs_b : fs_a}, {7'b0, ef});
      chk("occupied_cnt", i, {4'b0, (i == 1) ? occ_b : occ_a}, {4'b0, occ[i]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge();
    check_all();
  endtask

  task automatic run_n(input int n);
    repeat (n) step();
  endtask

  task automatic step_until_pos(input int target);
    for (int k = 0; k < 40 && !(run[0] && p[0] == target); k++) step();
  endtask

  initial begin
    cd[0] = 4; bc[0] = 1;
    cd[1] = 1; bc[1] = 0;
    model_reset();
    #2;
    check_all();
    run_n(2);
    rst_n = 1'b1;
    en    = 1'b1;
    spot  = 8'h00;
    run_n(25);

    spot = 8'h55;
    run_n(25);

    spot = 8'h00;
    run_n(20);
    step_until_pos(1);
    spot = 8'hFF;
    run_n(25);

    spot = 8'h3C;
    run_n(12);
    step_until_pos(6);
    en = 1'b0;
    run_n(3);
    en = 1'b1;
    run_n(15);

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) spot = 8'($urandom);
      en = ($urandom_range(0, 15) != 0);
      step();
    end
    en = 1'b1;
    run_n(12);

    step_until_pos(2);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run_n(2);
    rst_n = 1'b1;
    spot  = 8'hA6;
    run_n(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
